// File: rtl/conv_pkg.sv
// Shared types and helpers for the convolution output path.
package conv_pkg;

  localparam int unsigned CONV_ACC_W  = 32;
  localparam int unsigned CONV_DATA_W = 16;

  localparam logic signed [CONV_ACC_W-1:0] SAT_MAX =
    {{(CONV_ACC_W-CONV_DATA_W+1){1'b0}}, {(CONV_DATA_W-1){1'b1}}};
  localparam logic signed [CONV_ACC_W-1:0] SAT_MIN =
    {{(CONV_ACC_W-CONV_DATA_W+1){1'b1}}, {(CONV_DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  // Clamp a signed accumulator value into the signed pixel range.
  function automatic logic signed [CONV_DATA_W-1:0] sat_narrow(
    input logic signed [CONV_ACC_W-1:0] x
  );
    logic signed [CONV_ACC_W-1:0] c;
    if (x > SAT_MAX) begin
      c = SAT_MAX;
    end else if (x < SAT_MIN) begin
      c = SAT_MIN;
    end else begin
      c = x;
    end
    return c[CONV_DATA_W-1:0];
  endfunction

endpackage

// File: rtl/conv_requant.sv
// Combinational requantisation: arithmetic shift, optional ReLU, signed saturation.
module conv_requant
  import conv_pkg::*;
#(
  parameter int unsigned ACC_W  = CONV_ACC_W,
  parameter int unsigned DATA_W = CONV_DATA_W,
  parameter int unsigned SHIFT  = 8
) (
  input  logic                     relu_en,
  input  logic signed [ACC_W-1:0]  acc,
  output logic signed [DATA_W-1:0] pix
);

  logic signed [ACC_W-1:0] shifted;
  logic signed [ACC_W-1:0] clipped;

  always_comb begin
    shifted = acc >>> SHIFT;
    clipped = shifted;
    if (relu_en && shifted[ACC_W-1]) begin
      clipped = '0;
    end
  end

  // Default widths reuse the shared helper; other widths saturate locally.
  if (ACC_W == CONV_ACC_W && DATA_W == CONV_DATA_W) begin : g_pkg_sat
    assign pix = sat_narrow(clipped);
  end else begin : g_local_sat
    localparam logic signed [ACC_W-1:0] MAXV =
      {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MINV =
      {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
    logic signed [ACC_W-1:0] sat;
    always_comb begin
      sat = clipped;
      if (clipped > MAXV) begin
        sat = MAXV;
      end else if (clipped < MINV) begin
        sat = MINV;
      end
    end
    assign pix = sat[DATA_W-1:0];
  end

endmodule

// File: rtl/conv_out_writer.sv
// Drains PE-array results, requantises them and writes the output tile in raster order.
module conv_out_writer
  import conv_pkg::*;
#(
  parameter int unsigned ACC_W  = CONV_ACC_W,
  parameter int unsigned DATA_W = CONV_DATA_W,
  parameter int unsigned OUT_H  = 8,
  parameter int unsigned OUT_W  = 8,
  parameter int unsigned SHIFT  = 8,
  parameter int unsigned ADDR_W = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     relu_en,
  input  logic                     in_valid,
  input  logic signed [ACC_W-1:0]  in_data,
  output logic                     in_ready,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic signed [DATA_W-1:0] mem_wdata,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned TOTAL = OUT_H * OUT_W;
  localparam int unsigned ROW_W = (OUT_H > 1) ? $clog2(OUT_H) : 1;
  localparam int unsigned COL_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int unsigned CNT_W = $clog2(TOTAL + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TOTAL - 1);

  state_t                     state, state_nxt;
  logic [ROW_W-1:0]           row;
  logic [COL_W-1:0]           col;
  logic [CNT_W-1:0]           accept_cnt;
  logic                       relu_q;
  logic                       transfer;
  logic [ADDR_W-1:0]          addr_cur;
  logic signed [DATA_W-1:0]   pix;

  conv_requant #(
    .ACC_W  (ACC_W),
    .DATA_W (DATA_W),
    .SHIFT  (SHIFT)
  ) u_requant (
    .relu_en (relu_q),
    .acc     (in_data),
    .pix     (pix)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Leave RUN once the final write is on the bus, so done follows that write.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        busy     = 1'b1;
        in_ready = (accept_cnt < CNT_W'(TOTAL));
        if (mem_we && mem_addr == LAST_ADDR) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign transfer = in_valid && in_ready;
  assign addr_cur = ADDR_W'(32'(row) * OUT_W + 32'(col));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row        <= '0;
      col        <= '0;
      accept_cnt <= '0;
      relu_q     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      mem_we <= transfer;
      if (state == ST_IDLE && start) begin
        row        <= '0;
        col        <= '0;
        accept_cnt <= '0;
        relu_q     <= relu_en;
      end
      if (transfer) begin
        mem_addr   <= addr_cur;
        mem_wdata  <= pix;
        accept_cnt <= accept_cnt + 1'b1;
        if (col == COL_W'(OUT_W - 1)) begin
          col <= '0;
          row <= (row == ROW_W'(OUT_H - 1)) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_out_writer.sv
// Randomised bench for conv_out_writer against a count-based behavioural model.
module tb_conv_out_writer;

  localparam int T = 6;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic               relu_en;
  logic               in_valid;
  logic signed [31:0] in_data;
  logic               in_ready;
  logic               mem_we;
  logic [5:0]         mem_addr;
  logic signed [15:0] mem_wdata;
  logic               busy;
  logic               done;

  conv_out_writer #(
    .ACC_W  (32),
    .DATA_W (16),
    .OUT_H  (2),
    .OUT_W  (3),
    .SHIFT  (8),
    .ADDR_W (6)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .relu_en   (relu_en),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference requantisation: floor division by 256, ReLU, clamp to int16.
  function automatic longint fmodel(input longint x, input bit relu);
    longint q;
    q = x / 256;
    if (x < 0 && (x % 256) != 0) q = q - 1;
    if (relu && q < 0) q = 0;
    if (q > 32767) q = 32767;
    if (q < -32768) q = -32768;
    return q;
  endfunction

  // Model: phase 0 idle, 1 running, 2 done; writes numbered by acceptance order.
  int     ph = 0;
  int     acc = 0;
  bit     relu_m = 0;
  bit     m_took = 0;
  bit     e_we = 0, e_ready = 0, e_busy = 0, e_done = 0;
  longint e_addr = 0, e_wdata = 0;

  task automatic model_step();
    bit fin, took;
    if (!rst) begin
      ph = 0; acc = 0; relu_m = 0; m_took = 0;
      e_we = 0; e_addr = 0; e_wdata = 0;
    end else begin
      fin    = e_we && (e_addr == T - 1);
      took   = (ph == 1) && (acc < T) && in_valid;
      m_took = took;
      e_we   = took;
      case (ph)
        0: if (start) begin ph = 1; acc = 0; relu_m = relu_en; end
        1: begin
          if (took) begin
            e_addr  = acc;
            e_wdata = fmodel(longint'(in_data), relu_m);
            acc++;
          end
          if (fin) ph = 2;
        end
        default: ph = 0;
      endcase
    end
    e_ready = (ph == 1) && (acc < T);
    e_busy  = (ph != 0);
    e_done  = (ph == 2);
  endtask

  always @(posedge clk) model_step();

  int     wr_count = 0;
  int     done_count = 0;
  longint first_addr = -1;
  longint wr_data [8];

  task automatic compare_step();
    chk("in_ready",  in_ready,  e_ready);
    chk("mem_we",    mem_we,    e_we);
    chk("mem_addr",  mem_addr,  e_addr);
    chk("mem_wdata", mem_wdata, e_wdata);
    chk("busy",      busy,      e_busy);
    chk("done",      done,      e_done);
    if (mem_we) begin
      if (wr_count == 0) first_addr = mem_addr;
      if (wr_count < 8) wr_data[wr_count] = mem_wdata;
      wr_count++;
    end
    if (done) done_count++;
  endtask

  always @(negedge clk) compare_step();

  logic signed [31:0] feed [T];

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_stats();
    wr_count = 0; done_count = 0; first_addr = -1;
  endtask

  // mode 0: valid always, 1: valid pattern 1,0,0, 2: random valid.
  task automatic run_tile(input bit relu, input int mode, input bit inject);
    int idx, cyc;
    bit got_done;
    clear_stats();
    idx = 0; cyc = 0; got_done = 0;
    relu_en = relu;
    while (cyc < 300 && !got_done) begin
      start    = (cyc == 0) || (inject && cyc == 4);
      in_valid = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
      in_data  = (idx < T) ? feed[idx] : $urandom;
      tick();
      if (cyc == 0) relu_en = 1'($urandom_range(0, 1));
      start = 1'b0;
      if (m_took) idx++;
      cyc++;
      if (done) begin
        got_done = 1;
        start = inject;
        tick();
        start = 1'b0;
      end
    end
    in_valid = 1'b0;
    chk("tile_done_seen", got_done, 1);
    chk("tile_writes",    wr_count, T);
    chk("tile_done_once", done_count, 1);
    chk("tile_first_addr", first_addr, 0);
    chk("tile_consumed",  idx, T);
  endtask

  task automatic rand_feed();
    for (int i = 0; i < T; i++)
      feed[i] = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 4000)) - 32'sd2000;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; start = 1'b0; relu_en = 1'b0; in_valid = 1'b0; in_data = '0;

    chk("model_max",   fmodel(longint'(32'sh7FFFFFFF), 0), 32767);
    chk("model_min",   fmodel(-64'sh40000000, 0), -32768);
    chk("model_floor", fmodel(-300, 0), -2);
    chk("model_relu",  fmodel(-300, 1), 0);
    chk("model_k",     fmodel(256 * 5, 0), 5);

    repeat (3) tick();
    chk("rst_ready", in_ready, 0);
    chk("rst_we",    mem_we, 0);
    chk("rst_addr",  mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_busy",  busy, 0);
    chk("rst_done",  done, 0);
    rst = 1'b1;
    tick();

    // Ramp tile: 256*k must come out as k at address k.
    for (int k = 0; k < T; k++) feed[k] = 32'(256 * k);
    run_tile(0, 0, 0);
    for (int k = 0; k < T; k++) chk("ramp_data", wr_data[k], k);
    chk("ramp_idle_busy", busy, 0);

    feed[0] = 32'sh7FFFFFFF; feed[1] = -32'sh40000000; feed[2] = -32'sd300;
    feed[3] = 32'sd255;      feed[4] = -32'sd1;        feed[5] = 32'sh12345678;
    run_tile(0, 0, 0);
    chk("rq_sat_hi", wr_data[0], 32767);
    chk("rq_sat_lo", wr_data[1], -32768);
    chk("rq_floor",  wr_data[2], -2);
    run_tile(1, 0, 0);
    chk("rq_relu_hi", wr_data[0], 32767);
    chk("rq_relu_lo", wr_data[1], 0);
    chk("rq_relu",    wr_data[2], 0);

    rand_feed();
    run_tile(0, 1, 0);
    rand_feed();
    run_tile(1, 0, 1);
    rand_feed();
    run_tile(0, 1, 0);

    // Reset after three writes, then a fresh tile.
    clear_stats();
    for (int k = 0; k < T; k++) feed[k] = 32'(256 * (k + 10));
    start = 1'b1; relu_en = 1'b0; in_valid = 1'b1; in_data = feed[0];
    for (int c = 0; c < 20 && wr_count < 3; c++) begin
      tick();
      start = 1'b0;
      in_data = feed[(wr_count + 1) % T];
    end
    chk("pre_rst_writes", wr_count, 3);
    #1 rst = 1'b0;
    #1;
    chk("mid_rst_we",    mem_we, 0);
    chk("mid_rst_ready", in_ready, 0);
    chk("mid_rst_busy",  busy, 0);
    chk("mid_rst_addr",  mem_addr, 0);
    repeat (2) tick();
    chk("mid_rst_no_done", done_count, 0);
    rst = 1'b1;
    tick();
    run_tile(0, 0, 0);
    for (int k = 0; k < T; k++) chk("post_rst_data", wr_data[k], k + 10);

    for (int r = 0; r < 6; r++) begin
      rand_feed();
      run_tile(1'($urandom_range(0, 1)), 2, 1'($urandom_range(0, 1)));
    end

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
